// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the word-addressed data memory port. It takes one
//   load/store request at a time from the MEM stage and performs
//   LW/LH/LHU/LB/LBU/SW/SH/SB against a 32-bit word-only memory.
//   Sub-word stores use read-modify-write. Loads are extracted and then
//   sign- or zero-extended. Misaligned or out-of-range requests are answered
//   with resp_err and never touch memory. Byte lanes are little-endian.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (see below)
//   req_op                000 LW,001 LH,010 LHU,011 LB,100 LBU,101 SW,110 SH,111 SB
//   req_addr/req_wdata    byte address, store data
//   req_pc                instruction PC, replayed on dm_pc for write tracing
//   resp_valid            one-cycle completion pulse
//   resp_rdata/resp_err   load result (0 for stores and errors), error flag
//   dm_addr/dm_wdata      word index and write word
//   dm_read/dm_write      MemRead / MemWrite strobes
//   dm_pc                 latched req_pc
//   dm_rdata              read word, combinational from dm_addr
//   dbg_state_o           current FSM state, for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE, so req_valid is ignored
// while an operation is in flight. resp_valid is high for exactly one cycle
// per accepted request, and resp_rdata/resp_err are meaningful only then.
module mem_access_unit #(
  parameter int DM_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [31:0]      req_pc,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  output logic             dm_read,
  output logic             dm_write,
  output logic [31:0]      dm_pc,
  input  logic [31:0]      dm_rdata,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DM_AW+1:0]  addr_q, addr_d;   // in-range byte address only
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Request classification, evaluated on the raw request in IDLE.
  logic req_is_load, req_misalign, req_range, req_bad;
  always_comb begin
    req_is_load  = (req_op <= OP_LBU);
    req_misalign = ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00)) ||
                   ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0]);
    req_range    = (req_addr[31:DM_AW+2] != '0);
    req_bad      = req_misalign || req_range;
  end

  // Load extraction: shifting the word right by the lane offset puts the
  // addressed byte/half at bit 0 (halves are aligned, so addr[0] is 0).
  logic [31:0] ld_shift;
  logic [31:0] ld_val;
  always_comb begin
    ld_shift = dm_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      OP_LH:   ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      OP_LHU:  ld_val = {16'h0000, ld_shift[15:0]};
      OP_LB:   ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      OP_LBU:  ld_val = {24'h000000, ld_shift[7:0]};
      default: ld_val = dm_rdata;
    endcase
  end

  // Store word: replicate the store data across lanes and mask in the
  // addressed lane over the word captured in RMW_RD.
  logic [31:0] st_mask;
  logic [31:0] st_data;
  always_comb begin
    st_mask = 32'h0000_0000;
    st_data = wdata_q;
    case (op_q)
      OP_SB: begin
        st_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        st_data = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        st_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        st_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr[DM_AW+1:0];
          wdata_d = req_wdata;
          pc_d    = req_pc;
          rdata_d = 32'h0000_0000;
          err_d   = req_bad;
          if (req_bad)           state_d = S_RESP;
          else if (req_is_load)  state_d = S_RD;
          else if (req_op == OP_SW) state_d = S_WR;
          else                   state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        rdata_d = ld_val;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = dm_rdata;
        state_d = S_WR;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
      merge_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes are gated by reset so an aborted RMW never reaches memory.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    resp_rdata  = rdata_q;
    resp_err    = err_q;
    dm_addr     = addr_q[DM_AW+1:2];
    dm_read     = !reset && (state_q == S_RD || state_q == S_RMW_RD);
    dm_write    = !reset && (state_q == S_WR);
    dm_wdata    = (op_q == OP_SW) ? wdata_q : ((merge_q & ~st_mask) | (st_data & st_mask));
    dm_pc       = pc_q;
    dbg_state_o = state_q;
  end

endmodule
